// File: rtl/instr_sequencer.sv
// Program sequencer that feeds the my_fsm controller: it fetches each instruction
// and holds it stable until the controller pulses done. It stops at a halt opcode or at the end of memory.
module instr_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [9:0]    prog_data,
   input  logic          start,
   input  logic          done,
   output logic [3:0]    func,
   output logic [2:0]    in1,
   output logic [2:0]    in2,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic [4:0]    retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      HALT  = 2'b11
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [3:0]    func_q, func_d;
   logic [2:0]    in1_q, in1_d;
   logic [2:0]    in2_q, in2_d;
   logic          valid_q, valid_d;
   logic [4:0]    retired_q, retired_d;

   logic [9:0]    mem [DEPTH];
   logic [9:0]    fetch_word;
   logic          mem_we;
   logic          is_halt_op;

   // Writes are only taken while stopped, so they can never race the fetch.
   assign mem_we     = prog_we && !reset && (state_q == IDLE || state_q == HALT);
   assign fetch_word = mem[pc_q];
   assign is_halt_op = (fetch_word[9:6] == 4'b0000);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, HALT: if (start) state_d = ISSUE;
         ISSUE:      state_d = is_halt_op ? HALT : WAIT;
         WAIT: begin
            if (done) begin
               state_d = (pc_q == LAST_ADDR) ? HALT : ISSUE;
            end
         end
         default:    state_d = IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= '0;
         func_q    <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         valid_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         pc_q      <= pc_d;
         func_q    <= func_d;
         in1_q     <= in1_d;
         in2_q     <= in2_d;
         valid_q   <= valid_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      pc_d      = pc_q;
      func_d    = func_q;
      in1_d     = in1_q;
      in2_d     = in2_q;
      valid_d   = valid_q;
      retired_d = retired_q;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               pc_d      = '0;
               retired_d = '0;
            end
         end
         ISSUE: begin
            // A halt opcode leaves the last issued fields on the outputs.
            if (!is_halt_op) begin
               func_d  = fetch_word[9:6];
               in1_d   = fetch_word[5:3];
               in2_d   = fetch_word[2:0];
               valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (done) begin
               valid_d   = 1'b0;
               retired_d = (retired_q == 5'd31) ? retired_q : retired_q + 5'd1;
               if (pc_q != LAST_ADDR) begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Output decode
   always_comb begin
      func        = func_q;
      in1         = in1_q;
      in2         = in2_q;
      instr_valid = valid_q;
      pc          = pc_q;
      retired     = retired_q;
      busy        = (state_q == ISSUE) || (state_q == WAIT);
      halted      = (state_q == HALT);
   end

endmodule
